aes_128_feeder: RTL and testbench
=================================

# aes_128_feeder

Upstream feed stage for the pipelined `aes_128` core. It packs a 32-bit plaintext word stream into 128-bit blocks and holds the cipher key register, then presents `state`/`key` to the core. It tracks each issued block through the core's fixed-latency pipeline and registers the matching ciphertext with a valid strobe. The core has no valid or handshake of its own; this block supplies both.

## Interface
- `LATENCY`, 21, cycles from the core's issue cycle to the cycle in which `aes_out` holds that block's result (≥1).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `key_load`  in  1  load `key_in` into the key register.
- `key_in`  in  128  new cipher key.
- `din`  in  32  plaintext word; the first word of a block lands in [127:96].
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  word accepted when `din_valid & din_ready`.
- `flush`  in  1  discard a partially assembled block.
- `state`  out  128  block presented to the core's `state` input.
- `key`  out  128  key presented to the core's `key` input.
- `issue`  out  1  one-cycle pulse: `state`/`key` carry a new block this cycle.
- `aes_out`  in  128  the core's `out`.
- `dout`  out  128  registered ciphertext.
- `dout_valid`  out  1  one-cycle pulse: `dout` is valid.
- `busy`  out  1  partial block held, or blocks in flight.

## Operation
- Word counter `wcnt` (0..3) counts accepted words. Word *k* is written to bits [127-32k -: 32] of the assembly register.
- On the 4th accepted word:
  - `state` is updated with the full block, including that word.
  - `issue` is high for the following cycle.
  - `wcnt` wraps to 0.
- `state` holds its value between issues; the core's output on non-issue cycles is ignored.
- `din_ready` is 1 whenever out of reset. Blocks can therefore issue at most once every 4 cycles.
- `key_load` updates `key` at the next edge, at any time. Blocks already in flight are unaffected, because the core carries the key through its pipeline.
- If `key_load` and the 4th word occur in the same cycle, the new key applies to that block.
- `flush` resets `wcnt` to 0 and drops assembled words. If it coincides with a word accept, the flush wins and the word is dropped. It does not affect in-flight blocks or `key`.
- Valid tracking: a `LATENCY`-deep shift register is fed by `issue`. When its tail is 1, `dout <= aes_out` and `dout_valid` pulses the next cycle.
- In-flight counter, width clog2(`LATENCY`+2):
  - +1 on `issue`, −1 on `dout_valid`.
  - Both in the same cycle leaves it unchanged.
  - It never exceeds ceil(`LATENCY`/4)+1.
- `busy` = (`wcnt`≠0) | (in-flight≠0).

## Timing
- Reset values:
  - `wcnt`, shift register and in-flight counter are 0.
  - `state`, `key` and `dout` are 0.
  - `issue`, `dout_valid` and `busy` are 0.
  - `din_ready` is 0 while `rst` is asserted and 1 from the first edge after release.
- Accepting the 4th word at edge E0 makes `issue` high in cycle E0–E1.
- With `issue` high in cycle *t*, `aes_out` is valid in cycle *t*+`LATENCY` and `dout_valid` is high in cycle *t*+`LATENCY`+1. Total latency is `LATENCY`+1 cycles from `issue`.
- Reset mid-operation aborts everything: partial words, in-flight results and the key are lost, and no `dout_valid` appears for pre-reset blocks.
- Back-to-back blocks produce `dout_valid` pulses spaced exactly as their `issue` pulses.

## Configuration
- `AES_FEED_BSWAP_EN` defined: each `din` word is byte-reversed before packing, for little-endian word sources. `din` = 0xa8f64332 packs as 0x3243f6a8.
- Not defined: words are packed unchanged.
- `key_in` is never swapped.

## Structure
- Package `aes_feed_pkg`:
  - Constants `AES_BLK_W`=128, `AES_WORD_W`=32, `AES_WORDS_PER_BLK`=4.
  - Typedef `aes_blk_t` for 128-bit blocks.
- Sub-module `aes_valid_pipe` (parameter `LATENCY`):
  - Issue shift register, in-flight counter and tail strobe.
  - Reused by other fixed-latency wrappers.
- The `aes_128` core is instantiated by the parent. The bench connects `state`/`key`/`aes_out` to it.

## Test plan
- FIPS-197 vector:
  - Stimulus: `key_load` with key 0x2b7e151628aed2a6abf7158809cf4f3c, then words 0x3243f6a8, 0x885a308d, 0x313198a2, 0xe0370734.
  - Response: `dout` = 0x3925841d02dc09fbdc118597196a0b32, with `dout_valid` exactly `LATENCY`+1 cycles after `issue`.
- Back-to-back:
  - Stimulus: 3 blocks with no idle words, same key.
  - Response: three `dout_valid` pulses 4 cycles apart, each matching its reference ciphertext. `busy` falls the cycle after the last pulse.
- Key change:
  - Stimulus: `key_load` of all-zero key on the same cycle as the 4th word of block 2.
  - Response: block 1 is encrypted under the FIPS key; block 2 under key 0 (plaintext 0 gives 0x66e94bd4ef8a2c3b884cfa59ca342b2e).
- Flush:
  - Stimulus: 2 words, `flush`, then the full FIPS block.
  - Response: exactly one `dout_valid`, with the FIPS ciphertext.
- Reset mid-flight:
  - Stimulus: assert `rst` 5 cycles after `issue`.
  - Response: all outputs go to 0 immediately, and no `dout_valid` follows.
- With `AES_FEED_BSWAP_EN`:
  - Stimulus: byte-reversed FIPS words.
  - Response: the same FIPS ciphertext.

Source files
------------

// File: rtl/aes_128_feeder_pkg.sv
// Shared constants and types for the AES-128 feed stage.
package aes_feed_pkg;

  localparam int unsigned AES_BLK_W         = 128;
  localparam int unsigned AES_WORD_W        = 32;
  localparam int unsigned AES_WORDS_PER_BLK = 4;

  typedef logic [AES_BLK_W-1:0]  aes_blk_t;
  typedef logic [AES_WORD_W-1:0] aes_word_t;

  // Byte reversal for little-endian word sources.
  function automatic aes_word_t bswap32(aes_word_t w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_128_feeder_if.sv
// Bundle of the feeder's word-stream, core-facing and result signals.
// slave = the feeder itself, master = its environment (source, core, sink).
interface aes_128_feeder_if;
  import aes_feed_pkg::*;

  logic      key_load;
  aes_blk_t  key_in;
  aes_word_t din;
  logic      din_valid;
  logic      din_ready;
  logic      flush;
  aes_blk_t  state;
  aes_blk_t  key;
  logic      issue;
  aes_blk_t  aes_out;
  aes_blk_t  dout;
  logic      dout_valid;
  logic      busy;

  modport slave (
    input  key_load, key_in, din, din_valid, flush, aes_out,
    output din_ready, state, key, issue, dout, dout_valid, busy
  );

  modport master (
    output key_load, key_in, din, din_valid, flush, aes_out,
    input  din_ready, state, key, issue, dout, dout_valid, busy
  );

endinterface

// File: rtl/aes_valid_pipe.sv
// Valid tracker for a fixed-latency core: issue shift register, tail
// strobe used to capture the core output, and in-flight block counter.
module aes_valid_pipe #(
  parameter int unsigned LATENCY = 21
) (
  input  logic clk,
  input  logic rst,
  input  logic issue,
  output logic cap,
  output logic vld,
  output logic pending
);

  localparam int unsigned CNT_W = $clog2(LATENCY + 2);

  logic [LATENCY-1:0] sr;
  logic [CNT_W-1:0]   cnt;

  // Shift the issue marker along with the block through the core.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr[0] <= issue;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  // Tail high: the core output holds the tracked block's result this cycle.
  always_comb begin
    cap = sr[LATENCY-1];
  end

  // Result strobe lines up with the registered capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= 1'b0;
    end else begin
      vld <= cap;
    end
  end

  // Blocks issued but whose result strobe has not yet completed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (issue && !vld) begin
      cnt <= cnt + CNT_W'(1);
    end else if (!issue && vld) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Anything still in flight.
  always_comb begin
    pending = (cnt != '0);
  end

endmodule

// File: rtl/aes_128_feeder.sv
// Feed stage for the pipelined aes_128 core: packs 32-bit words into
// 128-bit blocks, holds the key, tracks issued blocks through the core
// and registers the matching ciphertext with a valid strobe.
// Build option: define AES_FEED_BSWAP_EN to byte-reverse each din word.
module aes_128_feeder
  import aes_feed_pkg::*;
#(
  parameter int unsigned LATENCY = 21
) (
  input logic              clk,
  input logic              rst,
  aes_128_feeder_if.slave  bus
);

  // Words 0..2 of the current block; word 3 goes straight into state.
  localparam int unsigned ASM_W = AES_BLK_W - AES_WORD_W;

  logic [1:0]       wcnt;
  logic [ASM_W-1:0] asm_q;
  aes_word_t        word;
  logic             accept;
  logic             cap;
  logic             vld;
  logic             pending;

  // Input word as packed into the block.
  always_comb begin
`ifdef AES_FEED_BSWAP_EN
    word = bswap32(bus.din);
`else
    word = bus.din;
`endif
  end

  // A flush in the same cycle drops the word.
  always_comb begin
    accept = bus.din_valid & bus.din_ready & ~bus.flush;
  end

  // Ready from the first edge after reset release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.din_ready <= 1'b0;
    end else begin
      bus.din_ready <= 1'b1;
    end
  end

  // Word counter and assembly of words 0..2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wcnt  <= '0;
      asm_q <= '0;
    end else if (bus.flush) begin
      wcnt <= '0;
    end else if (accept) begin
      for (int unsigned i = 0; i < AES_WORDS_PER_BLK - 1; i++) begin
        if (wcnt == 2'(i)) begin
          asm_q[ASM_W-1-AES_WORD_W*i -: AES_WORD_W] <= word;
        end
      end
      wcnt <= wcnt + 2'd1;
    end
  end

  // Present the full block and pulse issue on the 4th accepted word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.state <= '0;
      bus.issue <= 1'b0;
    end else begin
      bus.issue <= 1'b0;
      if (accept && wcnt == 2'(AES_WORDS_PER_BLK - 1)) begin
        bus.state <= {asm_q, word};
        bus.issue <= 1'b1;
      end
    end
  end

  // Key register; a load coinciding with the 4th word applies to that block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.key <= '0;
    end else if (bus.key_load) begin
      bus.key <= bus.key_in;
    end
  end

  aes_valid_pipe #(
    .LATENCY (LATENCY)
  ) u_vpipe (
    .clk     (clk),
    .rst     (rst),
    .issue   (bus.issue),
    .cap     (cap),
    .vld     (vld),
    .pending (pending)
  );

  // Capture the core output in the cycle its tracked block emerges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.dout <= '0;
    end else if (cap) begin
      bus.dout <= bus.aes_out;
    end
  end

  // Result strobe and activity flag.
  always_comb begin
    bus.dout_valid = vld;
    bus.busy       = (wcnt != '0) | pending;
  end

endmodule

// File: tb/tb_aes_128_feeder.sv
// Self-checking bench for aes_128_feeder. A behavioural AES-128 stands in
// for the pipelined core; a block-level model predicts every output.
module tb_aes_128_feeder;
  import aes_feed_pkg::*;

  localparam int LAT = 21;

  logic clk;
  logic rst;

  aes_128_feeder_if bus();

  aes_128_feeder #(
    .LATENCY (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int       e0;
    int       tv;
    aes_blk_t ct;
  } exp_t;

  int        n_tests = 0;
  int        n_fail  = 0;
  int        cyc     = 0;
  logic [7:0] sbox [256];
  aes_blk_t  slot [64];

  // block-level model
  exp_t      q[$];
  int        m_wcnt;
  aes_word_t m_words [4];
  aes_blk_t  m_key;
  aes_blk_t  m_state;
  logic      m_ready;
  logic      m_issue;

  int        last_issue;
  int        last_dv;
  aes_blk_t  last_dout;
  int        n_dv;

  localparam aes_blk_t FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam aes_blk_t FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam aes_blk_t FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam aes_blk_t ZERO_CT  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl1(input logic [7:0] b);
    return {b[6:0], b[7]};
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, r1, r2, r3, r4;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      r1 = rotl1(inv); r2 = rotl1(r1); r3 = rotl1(r2); r4 = rotl1(r3);
      sbox[x] = inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
    end
  endtask

  function automatic aes_blk_t aes_enc(input aes_blk_t pt, input aes_blk_t k);
    logic [31:0] w [44];
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [31:0] tmp;
    logic [7:0]  rc, a0, a1, a2, a3;
    aes_blk_t    b;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]], sbox[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = xt(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    b = pt ^ {w[0], w[1], w[2], w[3]};
    for (int r = 1; r <= 10; r++) begin
      for (int j = 0; j < 16; j++) s[j] = sbox[b[127-8*j -: 8]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) t[rr+4*c] = s[rr+4*((c+rr)%4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
          t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
          t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
          t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
          t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        end
      end
      for (int j = 0; j < 16; j++) b[127-8*j -: 8] = t[j];
      b = b ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    end
    return b;
  endfunction

  function automatic aes_blk_t rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // How a din word lands in the block.
  function automatic aes_word_t pack_word(input aes_word_t w);
`ifdef AES_FEED_BSWAP_EN
    return bswap32(w);
`else
    return w;
`endif
  endfunction

  // din word that packs as word i of a given block.
  function automatic aes_word_t feed_word(input aes_blk_t blk, input int i);
`ifdef AES_FEED_BSWAP_EN
    return bswap32(blk[127-32*i -: 32]);
`else
    return blk[127-32*i -: 32];
`endif
  endfunction

  task automatic model_reset();
    m_wcnt  = 0;
    m_key   = '0;
    m_state = '0;
    m_ready = 1'b0;
    m_issue = 1'b0;
    q.delete();
  endtask

  // One clock: update the model with the inputs seen at the edge, check
  // the DUT just after the edge, then advance the core stand-in.
  task automatic tick();
    aes_blk_t blk;
    int       infl;
    logic     dv_exp;
    @(posedge clk);
    cyc++;
    if (rst) begin
      model_reset();
    end else begin
      m_issue = 1'b0;
      if (bus.key_load) m_key = bus.key_in;
      if (bus.flush) begin
        m_wcnt = 0;
      end else if (bus.din_valid && m_ready) begin
        m_words[m_wcnt] = pack_word(bus.din);
        m_wcnt++;
        if (m_wcnt == 4) begin
          blk     = {m_words[0], m_words[1], m_words[2], m_words[3]};
          m_state = blk;
          m_issue = 1'b1;
          m_wcnt  = 0;
          q.push_back('{cyc, cyc + LAT + 1, aes_enc(blk, m_key)});
        end
      end
      m_ready = 1'b1;
    end
    #1;
    check("issue", bus.issue, m_issue);
    check("state", bus.state, m_state);
    check("key", bus.key, m_key);
    check("din_ready", bus.din_ready, m_ready);
    dv_exp = (q.size() > 0) && (q[0].tv == cyc);
    check("dout_valid", bus.dout_valid, dv_exp);
    if (dv_exp) check("dout", bus.dout, q[0].ct);
    infl = 0;
    foreach (q[i]) if (q[i].e0 < cyc) infl++;
    check("busy", bus.busy, (m_wcnt != 0) || (infl != 0));
    if (dv_exp) q.pop_front();
    if (bus.issue) last_issue = cyc;
    if (bus.dout_valid) begin
      last_dv   = cyc;
      last_dout = bus.dout;
      n_dv++;
    end
    slot[(cyc + LAT) % 64] = bus.issue ? aes_enc(bus.state, bus.key) : rand_blk();
    bus.aes_out = slot[cyc % 64];
  endtask

  task automatic idle(input int n);
    bus.din_valid = 1'b0;
    bus.key_load  = 1'b0;
    bus.flush     = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_word(input aes_word_t w);
    bus.din       = w;
    bus.din_valid = 1'b1;
    tick();
    bus.din_valid = 1'b0;
  endtask

  task automatic send_block(input aes_blk_t blk);
    for (int i = 0; i < 4; i++) send_word(feed_word(blk, i));
  endtask

  task automatic load_key(input aes_blk_t k);
    bus.key_load = 1'b1;
    bus.key_in   = k;
    tick();
    bus.key_load = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    bus.key_load  = 1'b0;
    bus.key_in    = '0;
    bus.din       = '0;
    bus.din_valid = 1'b0;
    bus.flush     = 1'b0;
    bus.aes_out   = '0;
    n_dv          = 0;
    last_issue    = 0;
    last_dv       = 0;
    last_dout     = '0;
    model_reset();
    for (int i = 0; i < 64; i++) slot[i] = rand_blk();
    build_sbox();

    // reference cipher sanity
    check("kat_fips_model", aes_enc(FIPS_PT, FIPS_KEY), FIPS_CT);
    check("kat_zero_model", aes_enc('0, '0), ZERO_CT);

    // reset state
    idle(3);
    rst = 1'b0;
    idle(2);

    // FIPS-197 vector with latency measurement
    load_key(FIPS_KEY);
    send_block(FIPS_PT);
    idle(LAT + 4);
    check("fips_latency", 32'(last_dv - last_issue), 32'(LAT + 1));
    check("fips_ct", last_dout, FIPS_CT);

    // back-to-back blocks, no idle words
    n_dv = 0;
    for (int b = 0; b < 3; b++) send_block(rand_blk());
    idle(LAT + 4);
    check("b2b_count", 32'(n_dv), 32'd3);

    // key change on the 4th word of block 2
    send_block(FIPS_PT);
    for (int i = 0; i < 3; i++) send_word('0);
    bus.key_load = 1'b1;
    bus.key_in   = '0;
    send_word('0);
    bus.key_load = 1'b0;
    idle(LAT + 4);
    check("keychg_ct", last_dout, ZERO_CT);

    // flush after 2 words, with a coinciding word that must be dropped
    load_key(FIPS_KEY);
    n_dv = 0;
    send_word(32'hdeadbeef);
    send_word(32'h01234567);
    bus.flush     = 1'b1;
    bus.din       = 32'hffffffff;
    bus.din_valid = 1'b1;
    tick();
    bus.flush     = 1'b0;
    bus.din_valid = 1'b0;
    send_block(FIPS_PT);
    idle(LAT + 4);
    check("flush_count", 32'(n_dv), 32'd1);
    check("flush_ct", last_dout, FIPS_CT);

    // reset 5 cycles after issue
    send_block(FIPS_PT);
    idle(5);
    #2;
    rst = 1'b1;
    #1;
    check("rst_state", bus.state, '0);
    check("rst_key", bus.key, '0);
    check("rst_dout", bus.dout, '0);
    check("rst_issue", bus.issue, 1'b0);
    check("rst_dout_valid", bus.dout_valid, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_din_ready", bus.din_ready, 1'b0);
    model_reset();
    idle(2);
    rst  = 1'b0;
    n_dv = 0;
    idle(LAT + 6);
    check("rst_no_dv", 32'(n_dv), 32'd0);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      bus.din_valid = ($urandom_range(3) != 0);
      bus.din       = $urandom;
      bus.key_load  = ($urandom_range(15) == 0);
      bus.key_in    = rand_blk();
      bus.flush     = ($urandom_range(31) == 0);
      tick();
    end
    idle(LAT + 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
